// File: rtl/adder_axil_pkg.sv
// rtl/adder_axil_pkg.sv - shared types and constants for the AXI4-Lite adder sequencer
package adder_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_A,
        ST_WB_A,
        ST_WR_B,
        ST_WB_B,
        ST_RD_AR,
        ST_RD_R,
        ST_RESP
    } seq_state_e;

    localparam logic [7:0] OPA_OFFSET = 8'h00;
    localparam logic [7:0] OPB_OFFSET = 8'h04;
    localparam logic [7:0] RES_OFFSET = 8'h08;

    localparam logic RESP_OKAY = 1'b0;

endpackage

// File: rtl/adder_axil_sequencer_if.sv
// rtl/adder_axil_sequencer_if.sv - AXI4-Lite bus between the sequencer and the adder slave
interface adder_axil_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic                    bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_write_channel.sv
// rtl/axil_write_channel.sv - one AXI4-Lite write: AW and W tracked independently, then B
module axil_write_channel
    import adder_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic [DATA_WIDTH-1:0]   start_data,
    input  logic                    resp_phase,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    req_done,
    output logic                    b_done,
    output logic                    b_err
);

    logic aw_done_q;
    logic w_done_q;
    logic aw_hs;
    logic w_hs;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign wstrb = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            awaddr    <= '0;
            wdata     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (start) begin
            awvalid   <= 1'b1;
            wvalid    <= 1'b1;
            awaddr    <= start_addr;
            wdata     <= start_data;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_hs) begin
                awvalid   <= 1'b0;
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                wvalid   <= 1'b0;
                w_done_q <= 1'b1;
            end
        end
    end

    // Done counts a handshake landing this cycle so the caller never waits an extra cycle.
    assign req_done = (aw_done_q | aw_hs) & (w_done_q | w_hs);
    assign bready   = resp_phase;
    assign b_done   = bready & bvalid;
    assign b_err    = b_done & (bresp != RESP_OKAY);

endmodule

// File: rtl/adder_axil_sequencer.sv
// rtl/adder_axil_sequencer.sv - drives one write-A, write-B, read-result sequence per request
module adder_axil_sequencer
    import adder_axil_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] OPA_ADDR   = ADDR_WIDTH'(OPA_OFFSET),
    parameter logic [ADDR_WIDTH-1:0] OPB_ADDR   = ADDR_WIDTH'(OPB_OFFSET),
    parameter logic [ADDR_WIDTH-1:0] RES_ADDR   = ADDR_WIDTH'(RES_OFFSET)
) (
    input  logic                  m1_axi_aclk,
    input  logic                  m1_axi_areset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_opa,
    input  logic [DATA_WIDTH-1:0] req_opb,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_err,
    adder_axil_sequencer_if.master m1_axi
);

    seq_state_e            state_q;
    seq_state_e            state_n;
    logic                  accept;
    logic                  wr_start;
    logic                  wr_done;
    logic                  b_done;
    logic                  b_err;
    logic                  ar_hs;
    logic                  r_hs;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] opb_q;
    logic [DATA_WIDTH-1:0] res_data_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic                  arvalid_q;
    logic                  err_q;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid & req_ready;
    assign ar_hs     = arvalid_q & m1_axi.arready;
    assign r_hs      = m1_axi.rready & m1_axi.rvalid;

    // Operand A goes straight into the write channel's registers on accept; B waits in opb_q.
    assign wr_start = accept | ((state_q == ST_WB_A) & b_done);
    assign wr_addr  = (state_q == ST_IDLE) ? OPA_ADDR : OPB_ADDR;
    assign wr_data  = (state_q == ST_IDLE) ? req_opa : opb_q;

    axil_write_channel #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr (
        .clk        (m1_axi_aclk),
        .rst        (m1_axi_areset),
        .start      (wr_start),
        .start_addr (wr_addr),
        .start_data (wr_data),
        .resp_phase ((state_q == ST_WB_A) || (state_q == ST_WB_B)),
        .awaddr     (m1_axi.awaddr),
        .awvalid    (m1_axi.awvalid),
        .awready    (m1_axi.awready),
        .wdata      (m1_axi.wdata),
        .wstrb      (m1_axi.wstrb),
        .wvalid     (m1_axi.wvalid),
        .wready     (m1_axi.wready),
        .bresp      (m1_axi.bresp),
        .bvalid     (m1_axi.bvalid),
        .bready     (m1_axi.bready),
        .req_done   (wr_done),
        .b_done     (b_done),
        .b_err      (b_err)
    );

    always_ff @(posedge m1_axi_aclk) begin
        if (m1_axi_areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:  if (accept)    state_n = ST_WR_A;
            ST_WR_A:  if (wr_done)   state_n = ST_WB_A;
            ST_WB_A:  if (b_done)    state_n = ST_WR_B;
            ST_WR_B:  if (wr_done)   state_n = ST_WB_B;
            ST_WB_B:  if (b_done)    state_n = ST_RD_AR;
            ST_RD_AR: if (ar_hs)     state_n = ST_RD_R;
            ST_RD_R:  if (r_hs)      state_n = ST_RESP;
            ST_RESP:  if (res_ready) state_n = ST_IDLE;
            default:                 state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge m1_axi_aclk) begin
        if (m1_axi_areset) begin
            opb_q      <= '0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            res_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                opb_q <= req_opb;
            end
            // AR only goes out once the second B response has been taken.
            if ((state_q == ST_WB_B) && b_done) begin
                arvalid_q <= 1'b1;
                araddr_q  <= RES_ADDR;
            end else if (ar_hs) begin
                arvalid_q <= 1'b0;
            end
            if ((state_q == ST_RD_R) && r_hs) begin
                res_data_q <= m1_axi.rdata;
            end
            if ((state_q == ST_RESP) && res_ready) begin
                err_q <= 1'b0;
            end else if (b_err || (r_hs && (m1_axi.rresp != RESP_OKAY))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign m1_axi.arvalid = arvalid_q;
    assign m1_axi.araddr  = araddr_q;
    assign m1_axi.rready  = (state_q == ST_RD_R);
    assign res_valid      = (state_q == ST_RESP);
    assign res_data       = res_data_q;
    assign res_err        = err_q;

endmodule

// File: tb/tb_adder_axil_sequencer.sv
// tb/tb_adder_axil_sequencer.sv - self-checking bench with a behavioural adder slave
module tb_adder_axil_sequencer;
    import adder_axil_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_opa;
    logic [DW-1:0] req_opb;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          res_err;

    adder_axil_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_axi ();

    adder_axil_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .m1_axi_aclk   (clk),
        .m1_axi_areset (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opa       (req_opa),
        .req_opb       (req_opb),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_err       (res_err),
        .m1_axi        (m1_axi)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural adder slave: zero-wait by default, awready/wready held off for a set number of cycles.
    int          aw_wait = 0;
    int          w_wait  = 0;
    bit          inj_en  = 1'b0;
    logic [7:0]  inj_addr = 8'h00;
    logic [31:0] mem [0:1];
    int          wr_cnt [0:2];
    int          aw_hi [0:1];
    int          w_hi [0:1];
    int          b_seen = 0;
    int          ar_early = 0;
    int          stab_viol = 0;
    int          aw_cnt = 0;
    int          w_cnt = 0;
    bit          aw_got, w_got, p_aw, p_w, p_b, p_ar, p_r, hold_aw, hold_w;
    logic [7:0]  aw_a, p_aw_a, p_ar_a, hold_aa;
    logic [31:0] w_d, p_w_d, hold_wd;

    always @(negedge clk) begin
        if (rst) begin
            m1_axi.awready = 1'b0; m1_axi.wready = 1'b0; m1_axi.arready = 1'b0;
            m1_axi.bvalid = 1'b0; m1_axi.bresp = 1'b0;
            m1_axi.rvalid = 1'b0; m1_axi.rresp = 1'b0; m1_axi.rdata = '0;
            aw_got = 0; w_got = 0; p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
            hold_aw = 0; hold_w = 0; aw_cnt = 0; w_cnt = 0;
            mem[0] = '0; mem[1] = '0;
        end else begin
            if (p_aw) begin aw_got = 1; aw_a = p_aw_a; end
            if (p_w)  begin w_got = 1;  w_d = p_w_d; end
            if (p_b)  begin m1_axi.bvalid = 1'b0; m1_axi.bresp = 1'b0; end
            if (p_r)  m1_axi.rvalid = 1'b0;
            if (p_ar) begin
                m1_axi.rvalid = 1'b1;
                m1_axi.rdata  = (p_ar_a == 8'h08) ? mem[0] + mem[1] : 32'hDEAD_BEEF;
            end
            if (aw_got && w_got && !m1_axi.bvalid) begin
                if (aw_a[3:2] == 2'd0) mem[0] = w_d;
                if (aw_a[3:2] == 2'd1) mem[1] = w_d;
                if (aw_a[3:2] != 2'd3) wr_cnt[int'(aw_a[3:2])]++;
                m1_axi.bvalid = 1'b1;
                m1_axi.bresp  = inj_en && (aw_a == inj_addr);
                aw_got = 0; w_got = 0;
            end
            if (hold_aw && (!m1_axi.awvalid || m1_axi.awaddr != hold_aa)) stab_viol++;
            if (hold_w && (!m1_axi.wvalid || m1_axi.wdata != hold_wd)) stab_viol++;
            if (m1_axi.awvalid && !aw_got) begin aw_cnt++; m1_axi.awready = aw_cnt > aw_wait; end
            else begin aw_cnt = 0; m1_axi.awready = 1'b0; end
            if (m1_axi.wvalid && !w_got) begin w_cnt++; m1_axi.wready = w_cnt > w_wait; end
            else begin w_cnt = 0; m1_axi.wready = 1'b0; end
            m1_axi.arready = 1'b1;
            if (m1_axi.arvalid && b_seen < 2) ar_early++;
            p_aw = m1_axi.awvalid && m1_axi.awready;
            p_aw_a = m1_axi.awaddr;
            if (p_aw && !m1_axi.awaddr[3]) aw_hi[int'(m1_axi.awaddr[2])] = aw_cnt;
            p_w = m1_axi.wvalid && m1_axi.wready;
            p_w_d = m1_axi.wdata;
            if (p_w && !m1_axi.awaddr[3]) w_hi[int'(m1_axi.awaddr[2])] = w_cnt;
            hold_aw = m1_axi.awvalid && !m1_axi.awready; hold_aa = m1_axi.awaddr;
            hold_w  = m1_axi.wvalid && !m1_axi.wready;   hold_wd = m1_axi.wdata;
            p_b = m1_axi.bvalid && m1_axi.bready;
            if (p_b) b_seen++;
            p_ar = m1_axi.arvalid && m1_axi.arready; p_ar_a = m1_axi.araddr;
            p_r = m1_axi.rvalid && m1_axi.rready;
        end
    end

    typedef struct {
        logic [31:0] opa;
        logic [31:0] opb;
        int          aw_wait;
        int          w_wait;
        bit          inj;
        logic [7:0]  inj_addr;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input int aww, input int ww,
                                input bit inj, input logic [7:0] ia, input logic [31:0] ed, input bit ee);
        vec_t v;
        v.opa = a; v.opb = b; v.aw_wait = aww; v.w_wait = ww;
        v.inj = inj; v.inj_addr = ia; v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge where res_valid is first seen.
    task automatic run_req(input logic [31:0] a, input logic [31:0] b, output logic [31:0] d,
                           output logic e, output int lat, output bit ok);
        int n;
        wr_cnt[0] = 0; wr_cnt[1] = 0; wr_cnt[2] = 0; b_seen = 0;
        d = '0; e = 1'b0; lat = 0; ok = 1'b0;
        req_opa = a; req_opb = b; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check("req_accept", req_ready, 1);
        if (!req_ready) begin req_valid = 1'b0; return; end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 300) begin @(negedge clk); lat++; end
        check("res_arrival", res_valid, 1);
        if (!res_valid) return;
        d = res_data; e = res_err; ok = 1'b1;
    endtask

    vec_t        vecs [14];
    logic [31:0] d;
    logic        e;
    int          lat;
    bit          ok;

    initial begin
        int held, n, k, m, cyc, mx;
        bit change;
        int acc [2];
        int hs [2];
        logic [31:0] got [2];

        rst = 1'b1; req_valid = 1'b0; req_opa = '0; req_opb = '0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_err", res_err, 0);
        check("rst_axi_ctrl", {m1_axi.awvalid, m1_axi.wvalid, m1_axi.arvalid, m1_axi.bready, m1_axi.rready}, 0);
        check("rst_axi_addr", {m1_axi.awaddr, m1_axi.araddr, m1_axi.wdata}, 0);
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = mk(32'd39, 32'd40, 0, 0, 1'b0, 8'h00, 32'd79, 1'b0);
        vecs[1] = mk(32'd39, 32'd40, 3, 0, 1'b0, 8'h00, 32'd79, 1'b0);
        vecs[2] = mk(32'd39, 32'd40, 0, 0, 1'b1, 8'h04, 32'd79, 1'b1);
        vecs[3] = mk(32'd1, 32'd2, 0, 0, 1'b0, 8'h00, 32'd3, 1'b0);
        vecs[4] = mk(32'hFFFF_FFFF, 32'd1, 0, 2, 1'b0, 8'h00, 32'd0, 1'b0);
        vecs[5] = mk(32'd100, 32'd200, 1, 1, 1'b1, 8'h00, 32'd300, 1'b1);
        for (int i = 6; i < 14; i++) begin
            logic [31:0] ra, rb;
            bit ri;
            ra = $urandom; rb = $urandom;
            ri = ($urandom_range(0, 3) == 0);
            vecs[i] = mk(ra, rb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ri,
                         ($urandom_range(0, 1) == 1) ? 8'h04 : 8'h00, ra + rb, ri);
        end

        for (int i = 0; i < 14; i++) begin
            aw_wait = vecs[i].aw_wait; w_wait = vecs[i].w_wait;
            inj_en = vecs[i].inj; inj_addr = vecs[i].inj_addr;
            run_req(vecs[i].opa, vecs[i].opb, d, e, lat, ok);
            if (ok) begin
                @(negedge clk);
                mx = (vecs[i].aw_wait > vecs[i].w_wait) ? vecs[i].aw_wait : vecs[i].w_wait;
                check($sformatf("v%0d_data", i), d, vecs[i].exp_data);
                check($sformatf("v%0d_err", i), e, vecs[i].exp_err);
                check($sformatf("v%0d_latency", i), lat, 7 + 2 * mx);
                check($sformatf("v%0d_writes", i), {wr_cnt[0][7:0], wr_cnt[1][7:0], wr_cnt[2][7:0]}, 24'h010100);
                check($sformatf("v%0d_aw_cycles", i), aw_hi[0], vecs[i].aw_wait + 1);
                check($sformatf("v%0d_w_cycles", i), w_hi[0], vecs[i].w_wait + 1);
                check($sformatf("v%0d_idle", i), {req_ready, res_valid}, 2'b10);
            end
        end
        aw_wait = 0; w_wait = 0; inj_en = 1'b0;

        // Client stalls the response: everything must freeze.
        res_ready = 1'b0;
        run_req(32'd39, 32'd40, d, e, lat, ok);
        if (ok) begin
            held = 0;
            for (int j = 0; j < 5; j++) begin
                @(negedge clk);
                if (!res_valid || res_data !== d || req_ready ||
                    m1_axi.awvalid || m1_axi.wvalid || m1_axi.arvalid || m1_axi.bready || m1_axi.rready)
                    held++;
            end
            check("stall_hold", held, 0);
            check("stall_data", d, 79);
            res_ready = 1'b1;
            @(negedge clk);
            check("stall_release", {req_ready, res_valid}, 2'b10);
        end
        res_ready = 1'b1;

        // Reset while waiting on the OPB write response.
        req_opa = 32'd5; req_opb = 32'd6; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(m1_axi.bready && m1_axi.awaddr == 8'h04) && n < 50) begin @(negedge clk); n++; end
        check("wbb_reached", m1_axi.bready, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_axi_ctrl", {m1_axi.awvalid, m1_axi.wvalid, m1_axi.arvalid, m1_axi.bready, m1_axi.rready}, 0);
        check("mid_rst_handshake", {req_ready, res_valid}, 2'b10);
        check("mid_rst_res", {res_data, res_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_req(32'hFFFF_FFFF, 32'd1, d, e, lat, ok);
        if (ok) begin
            @(negedge clk);
            check("post_rst_wrap", {e, d}, 0);
        end

        // Back-to-back with req_valid held: next accept only after the response handshake.
        res_ready = 1'b1; req_opa = 32'd10; req_opb = 32'd20; req_valid = 1'b1;
        k = 0; m = 0; cyc = 0; change = 0;
        acc[0] = -1; acc[1] = -1; hs[0] = -9; hs[1] = -9; got[0] = '0; got[1] = '0;
        while (m < 2 && cyc < 200) begin
            if (req_valid && req_ready && k < 2) begin acc[k] = cyc; k++; change = 1; end
            if (res_valid && res_ready) begin hs[m] = cyc; got[m] = res_data; m++; end
            @(negedge clk);
            cyc++;
            if (change) begin
                if (k == 1) begin req_opa = 32'd100; req_opb = 32'd23; end
                else req_valid = 1'b0;
                change = 0;
            end
        end
        req_valid = 1'b0;
        check("b2b_responses", m, 2);
        check("b2b_second_accept", acc[1], hs[0] + 1);
        check("b2b_first_sum", got[0], 30);
        check("b2b_second_sum", got[1], 123);

        check("axi_stable_while_valid", stab_viol, 0);
        check("ar_after_both_b", ar_early, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
